// File: rtl/uart_debug_loader.sv
// Debug UART command engine: decodes write-word (0x57) and read-word (0x52) frames
// into accesses on instruction RAM port b and streams the response bytes back.
module uart_debug_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        web,
  output logic [29:0] addrb,
  output logic [31:0] dinb,
  input  logic [31:0] doutb,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam logic [7:0]  OP_WRITE      = 8'h57;
  localparam logic [7:0]  OP_READ       = 8'h52;
  localparam logic [7:0]  WRITE_ACK     = 8'h4B;
  localparam logic [23:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[23:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WRITE,
    S_READ,
    S_TX
  } state_t;

  state_t      state_reg;
  logic        is_write_reg;
  logic [1:0]  byte_cnt_reg;
  logic [23:0] timeout_reg;
  logic [1:0]  addr_lo_reg;
  logic [31:0] tx_shift_reg;
  logic [2:0]  tx_cnt_reg;
  logic        err_event;
  logic        in_field;
  logic        timed_out;

  assign busy      = (state_reg != S_IDLE);
  assign in_field  = (state_reg == S_ADDR) || (state_reg == S_DATA);
  // A strobe in the same cycle the limit is reached wins over the abort.
  assign timed_out = in_field && !rx_valid && (timeout_reg == TIMEOUT_LIMIT);

  always_comb begin
    err_event = 1'b0;
    if (timed_out) begin
      err_event = 1'b1;
    end else if (rx_valid) begin
      case (state_reg)
        S_IDLE:                 err_event = (rx_data != OP_WRITE) && (rx_data != OP_READ);
        S_WRITE, S_READ, S_TX:  err_event = 1'b1;
        default:                err_event = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      is_write_reg <= 1'b0;
      byte_cnt_reg <= 2'd0;
      timeout_reg  <= 24'd0;
      addr_lo_reg  <= 2'd0;
      tx_shift_reg <= 32'd0;
      tx_cnt_reg   <= 3'd0;
      tx_valid     <= 1'b0;
      tx_data      <= 8'd0;
      web          <= 1'b0;
      addrb        <= 30'd0;
      dinb         <= 32'd0;
      err_cnt      <= 8'd0;
    end else begin
      web <= 1'b0;
      if (err_event && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end

      case (state_reg)
        S_IDLE: begin
          if (rx_valid && ((rx_data == OP_WRITE) || (rx_data == OP_READ))) begin
            is_write_reg <= (rx_data == OP_WRITE);
            byte_cnt_reg <= 2'd0;
            timeout_reg  <= 24'd0;
            state_reg    <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (rx_valid) begin
            timeout_reg  <= 24'd0;
            // Byte address bits [1:0] are held aside so only word bits land in addrb.
            addrb        <= {addrb[21:0], addr_lo_reg, rx_data[7:2]};
            addr_lo_reg  <= rx_data[1:0];
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              state_reg <= is_write_reg ? S_DATA : S_READ;
            end
          end else if (timed_out) begin
            state_reg <= S_IDLE;
          end else begin
            timeout_reg <= timeout_reg + 24'd1;
          end
        end

        S_DATA: begin
          if (rx_valid) begin
            timeout_reg  <= 24'd0;
            dinb         <= {dinb[23:0], rx_data};
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              web       <= 1'b1;
              state_reg <= S_WRITE;
            end
          end else if (timed_out) begin
            state_reg <= S_IDLE;
          end else begin
            timeout_reg <= timeout_reg + 24'd1;
          end
        end

        S_WRITE: begin
          tx_data    <= WRITE_ACK;
          tx_valid   <= 1'b1;
          tx_cnt_reg <= 3'd1;
          state_reg  <= S_TX;
        end

        S_READ: begin
          tx_data      <= doutb[31:24];
          tx_shift_reg <= {doutb[23:0], 8'h00};
          tx_valid     <= 1'b1;
          tx_cnt_reg   <= 3'd4;
          state_reg    <= S_TX;
        end

        S_TX: begin
          if (tx_valid && tx_ready) begin
            tx_cnt_reg <= tx_cnt_reg - 3'd1;
            if (tx_cnt_reg == 3'd1) begin
              tx_valid  <= 1'b0;
              state_reg <= S_IDLE;
            end else begin
              tx_data      <= tx_shift_reg[31:24];
              tx_shift_reg <= {tx_shift_reg[23:0], 8'h00};
            end
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_debug_loader.sv
// Randomized frame-level bench for uart_debug_loader with a word-array RAM on port b
// and a frame-level reference model of expected RAM writes, tx bytes and err_cnt.
module tb_uart_debug_loader;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic        web;
  logic [29:0] addrb;
  logic [31:0] dinb;
  logic [31:0] doutb;
  logic        busy;
  logic [7:0]  err_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_debug_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .web      (web),
    .addrb    (addrb),
    .dinb     (dinb),
    .doutb    (doutb),
    .busy     (busy),
    .err_cnt  (err_cnt)
  );

  // RAM seen by the DUT: 256 words, indexed by the low word-address bits.
  logic [31:0] ram [256] = '{default: 32'h0};
  assign doutb = ram[addrb[7:0]];
  always @(posedge clk) if (web) ram[addrb[7:0]] <= dinb;

  // Reference model state.
  logic [31:0] model_mem [256] = '{default: 32'h0};
  int          exp_err = 0;
  logic [61:0] exp_web_q[$];
  logic [61:0] got_web_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  got_tx_q[$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Monitor: record RAM writes and tx transfers, and check stall stability.
  logic       stalled_prev = 1'b0;
  logic [7:0] stalled_data = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled_prev <= 1'b0;
    end else begin
      if (stalled_prev) begin
        check_eq("tx_hold_valid", {63'd0, tx_valid}, 64'd1);
        check_eq("tx_hold_data", {56'd0, tx_data}, {56'd0, stalled_data});
      end
      if (web) got_web_q.push_back({addrb, dinb});
      if (tx_valid && tx_ready) got_tx_q.push_back(tx_data);
      stalled_prev <= tx_valid && !tx_ready;
      stalled_data <= tx_data;
    end
  end

  // tx_ready driver: 0 = always ready, 1 = random, 2 = stall ~10 cycles then toggle.
  int tx_mode = 0;
  int stall_cnt = 0;
  always begin
    @(posedge clk);
    #1;
    if (tx_mode != 2) stall_cnt = 0;
    else if (tx_valid) stall_cnt++;
    case (tx_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = (stall_cnt > 10) && (stall_cnt % 2 == 1);
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat ($urandom_range(0, gap_max)) tick();
  endtask

  task automatic bump_err();
    if (exp_err < 255) exp_err++;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    if (busy) check_eq("idle_wait_expired", {63'd0, busy}, 64'd0);
  endtask

  task automatic check_frame(input string tag);
    check_eq({tag, "_web_count"}, 64'(got_web_q.size()), 64'(exp_web_q.size()));
    for (int i = 0; i < got_web_q.size() && i < exp_web_q.size(); i++)
      check_eq({tag, "_web_addr_data"}, {2'd0, got_web_q[i]}, {2'd0, exp_web_q[i]});
    check_eq({tag, "_tx_count"}, 64'(got_tx_q.size()), 64'(exp_tx_q.size()));
    for (int i = 0; i < got_tx_q.size() && i < exp_tx_q.size(); i++)
      check_eq({tag, "_tx_byte"}, {56'd0, got_tx_q[i]}, {56'd0, exp_tx_q[i]});
    check_eq({tag, "_err_cnt"}, {56'd0, err_cnt}, 64'(exp_err));
    check_eq({tag, "_busy"}, {63'd0, busy}, 64'd0);
    $display("frame %s: web=%0d tx=%0d err_cnt=%0d", tag, got_web_q.size(), got_tx_q.size(), err_cnt);
    got_web_q.delete();
    exp_web_q.delete();
    got_tx_q.delete();
    exp_tx_q.delete();
  endtask

  task automatic send_addr(input logic [31:0] addr, input int gap);
    for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8], gap);
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data, input int gap);
    exp_web_q.push_back({addr[31:2], data});
    model_mem[addr[9:2]] = data;
    exp_tx_q.push_back(8'h4B);
    send_byte(8'h57, gap);
    send_addr(addr, gap);
    for (int i = 3; i >= 0; i--) send_byte(data[i*8 +: 8], gap);
    wait_idle();
    check_frame(tag);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input int gap, input bit inject);
    logic [31:0] w;
    w = model_mem[addr[9:2]];
    for (int i = 3; i >= 0; i--) exp_tx_q.push_back(w[i*8 +: 8]);
    send_byte(8'h52, gap);
    send_addr(addr, gap);
    if (inject) begin
      repeat (3) tick();
      send_byte(8'h33, 0);
      bump_err();
    end
    wait_idle();
    check_frame(tag);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    return {r[31:10], 3'b000, 3'($urandom_range(0, 7)), r[1:0]};
  endfunction

  initial begin
    logic [7:0] b;
    repeat (3) tick();
    check_eq("rst_web", {63'd0, web}, 64'd0);
    check_eq("rst_addrb", {34'd0, addrb}, 64'd0);
    check_eq("rst_dinb", {32'd0, dinb}, 64'd0);
    check_eq("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    check_eq("rst_tx_data", {56'd0, tx_data}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_err_cnt", {56'd0, err_cnt}, 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    do_write("dir_write", 32'h0000_0108, 32'hDEAD_BEEF, 0);
    do_read("dir_read", 32'h0000_010B, 0, 1'b0);
    check_eq("dir_read_addrb", {34'd0, addrb}, 64'h42);

    send_byte(8'h00, 0);
    bump_err();
    do_read("bad_op_read", 32'h0000_0108, 1, 1'b0);

    // Stall mid-frame long enough to trip the inter-byte timeout.
    send_byte(8'h57, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    repeat (20) tick();
    bump_err();
    check_frame("timeout");
    do_write("post_timeout_write", 32'h0000_0200, 32'h1234_5678, 1);

    tx_mode = 2;
    do_read("backpressure_read", 32'h0000_0108, 0, 1'b1);
    tx_mode = 0;

    for (int n = 0; n < 40; n++) begin
      int op;
      op = $urandom_range(0, 9);
      tx_mode = $urandom_range(0, 1);
      if (op == 0) begin
        b = 8'($urandom);
        if (b == 8'h57 || b == 8'h52) b = 8'h00;
        send_byte(b, 1);
        bump_err();
        check_frame("rand_bad_op");
      end else if (op < 5) begin
        do_write("rand_write", rand_addr(), $urandom, 2);
      end else begin
        do_read("rand_read", rand_addr(), 2, 1'b0);
      end
    end
    tx_mode = 0;
    repeat (2) tick();

    // Reset in the middle of a write's data field.
    send_byte(8'h57, 0);
    send_addr(32'h0000_0300, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_web", {63'd0, web}, 64'd0);
    check_eq("midrst_addrb", {34'd0, addrb}, 64'd0);
    check_eq("midrst_dinb", {32'd0, dinb}, 64'd0);
    check_eq("midrst_tx_valid", {63'd0, tx_valid}, 64'd0);
    check_eq("midrst_tx_data", {56'd0, tx_data}, 64'd0);
    check_eq("midrst_busy", {63'd0, busy}, 64'd0);
    check_eq("midrst_err_cnt", {56'd0, err_cnt}, 64'd0);
    exp_err = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_frame("midrst");
    do_write("post_reset_write", 32'h0000_0304, 32'hCAFE_F00D, 1);
    do_read("post_reset_read", 32'h0000_0304, 0, 1'b0);

    for (int n = 0; n < 260; n++) begin
      send_byte(8'hA5, 0);
      bump_err();
    end
    tick();
    check_frame("err_saturate");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
